// File: rtl/avalon_bus_arbiter_if.sv
// Avalon-MM port bundle shared by the arbiter's master-facing and slave-facing sides.
interface avalon_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (output address, read, write, writedata, byteenable,
                  input  waitrequest, readdata);
  modport slave  (input  address, read, write, writedata, byteenable,
                  output waitrequest, readdata);
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter in front of one slave, one transaction per grant.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; otherwise m0 has fixed priority.
module avalon_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  m0,
  avalon_bus_arbiter_if.slave  m1,
  avalon_bus_arbiter_if.master s,
  output logic [1:0]           grant,
  output logic                 timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                rd;
    logic                wr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] be;
  } req_t;

  state_t     state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic       m0_req, m1_req;
  req_t       m0_rq, m1_rq, sel;
  logic       m0_wait, m1_wait;

  assign m0_req = m0.read | m0.write;
  assign m1_req = m1.read | m1.write;
  assign m0_rq  = '{addr: m0.address, rd: m0.read, wr: m0.write, wdata: m0.writedata, be: m0.byteenable};
  assign m1_rq  = '{addr: m1.address, rd: m1.read, wr: m1.write, wdata: m1.writedata, be: m1.byteenable};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_nxt = last_grant ? GRANT0 : GRANT1;
`else
          state_nxt = GRANT0;
`endif
        end else if (m0_req) state_nxt = GRANT0;
        else if (m1_req)     state_nxt = GRANT1;
      end
      // A dropped request ends the grant without updating fairness history.
      GRANT0: begin
        if (!m0_req) state_nxt = IDLE;
        else if (!s.waitrequest) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b0;
        end
      end
      GRANT1: begin
        if (!m1_req) state_nxt = IDLE;
        else if (!s.waitrequest) begin
          state_nxt      = IDLE;
          last_grant_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel     = '0;
    m0_wait = 1'b1;
    m1_wait = 1'b1;
    grant   = 2'b00;
    case (state)
      GRANT0: begin
        sel     = m0_rq;
        m0_wait = s.waitrequest;
        grant   = 2'b01;
      end
      GRANT1: begin
        sel     = m1_rq;
        m1_wait = s.waitrequest;
        grant   = 2'b10;
      end
      default: ;
    endcase
  end

  assign s.address     = sel.addr;
  assign s.read        = sel.rd;
  assign s.write       = sel.wr;
  assign s.writedata   = sel.wdata;
  assign s.byteenable  = sel.be;
  assign m0.waitrequest = m0_wait;
  assign m1.waitrequest = m1_wait;
  assign m0.readdata   = s.readdata;
  assign m1.readdata   = s.readdata;

  // With TIMEOUT_CYCLES=0 CNT_MAX is 0, so the counter never leaves 0 and timeout never sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else if (state == IDLE) begin
      stall_cnt <= '0;
    end else if (s.waitrequest && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == CNT_MAX - 1'b1) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed and random checks of avalon_bus_arbiter against a cycle-level ownership model.
module tb_avalon_bus_arbiter;
  localparam int TMO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant, grant_z;
  logic       timeout, timeout_z;

  avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if(), m1_if(), s_if();
  avalon_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0z(), m1z(), sz();

  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) u_dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .timeout(timeout));

  // Second copy with the timeout disabled, fed the same stimulus.
  avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(0)) u_dut_z (
    .clk(clk), .reset(reset), .m0(m0z), .m1(m1z), .s(sz),
    .grant(grant_z), .timeout(timeout_z));

  assign m0z.address = m0_if.address;  assign m0z.read = m0_if.read;
  assign m0z.write = m0_if.write;      assign m0z.writedata = m0_if.writedata;
  assign m0z.byteenable = m0_if.byteenable;
  assign m1z.address = m1_if.address;  assign m1z.read = m1_if.read;
  assign m1z.write = m1_if.write;      assign m1z.writedata = m1_if.writedata;
  assign m1z.byteenable = m1_if.byteenable;
  assign sz.waitrequest = s_if.waitrequest;
  assign sz.readdata = s_if.readdata;

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int owner, last_win, stall;   // owner: -1 idle, else master index
  bit tmo;
  int owner_n, last_n, stall_n;
  bit tmo_n;
  logic [1:0] gseq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; last_win = 1; stall = 0; tmo = 1'b0;
    owner_n = -1; last_n = 1; stall_n = 0; tmo_n = 1'b0;
  endtask

  // Sample at the falling edge, compare everything, and compute the model's next state.
  task automatic mid();
    logic r0, r1, sw;
    logic [1:0] g_exp;
    @(negedge clk);
    r0 = m0_if.read | m0_if.write;
    r1 = m1_if.read | m1_if.write;
    sw = s_if.waitrequest;
    g_exp = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    chk("grant", grant, g_exp);
    chk("timeout", timeout, tmo);
    chk("timeout_disabled", timeout_z, 1'b0);
    if (owner == 0) begin
      chk("s_read", s_if.read, m0_if.read);
      chk("s_write", s_if.write, m0_if.write);
      chk("s_address", s_if.address, m0_if.address);
      chk("s_writedata", s_if.writedata, m0_if.writedata);
      chk("s_byteenable", s_if.byteenable, m0_if.byteenable);
      chk("m0_wait", m0_if.waitrequest, sw);
      chk("m1_wait", m1_if.waitrequest, 1'b1);
      if (r0 && !sw) chk("m0_readdata", m0_if.readdata, s_if.readdata);
    end else if (owner == 1) begin
      chk("s_read", s_if.read, m1_if.read);
      chk("s_write", s_if.write, m1_if.write);
      chk("s_address", s_if.address, m1_if.address);
      chk("s_writedata", s_if.writedata, m1_if.writedata);
      chk("s_byteenable", s_if.byteenable, m1_if.byteenable);
      chk("m1_wait", m1_if.waitrequest, sw);
      chk("m0_wait", m0_if.waitrequest, 1'b1);
      if (r1 && !sw) chk("m1_readdata", m1_if.readdata, s_if.readdata);
    end else begin
      chk("idle_s_read", s_if.read, 1'b0);
      chk("idle_s_write", s_if.write, 1'b0);
      chk("idle_s_address", s_if.address, 32'h0);
      chk("idle_s_writedata", s_if.writedata, 32'h0);
      chk("idle_s_byteenable", s_if.byteenable, 4'h0);
      chk("idle_m0_wait", m0_if.waitrequest, 1'b1);
      chk("idle_m1_wait", m1_if.waitrequest, 1'b1);
    end
    owner_n = owner; last_n = last_win; stall_n = stall; tmo_n = tmo;
    if (owner < 0) begin
      stall_n = 0;
      if (r0 && r1) owner_n = RR ? ((last_win == 0) ? 1 : 0) : 0;
      else if (r0)  owner_n = 0;
      else if (r1)  owner_n = 1;
    end else begin
      if (sw && stall < TMO) begin
        stall_n = stall + 1;
        if (stall_n == TMO) tmo_n = 1'b1;
      end
      if (!((owner == 0) ? r0 : r1)) owner_n = -1;
      else if (!sw) begin
        owner_n = -1;
        last_n  = owner;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    owner = owner_n; last_win = last_n; stall = stall_n; tmo = tmo_n;
  endtask

  task automatic m_clear();
    m0_if.address = '0; m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.writedata = '0; m0_if.byteenable = '0;
    m1_if.address = '0; m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.writedata = '0; m1_if.byteenable = '0;
  endtask

  initial begin
    bit act0, act1, done0, done1;
    m_clear();
    s_if.waitrequest = 1'b0;
    s_if.readdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    mid();
    reset = 1'b0;
    adv();

    // m0 single read, zero wait
    m0_if.read = 1'b1; m0_if.address = 32'hBFC0_0000; m0_if.byteenable = 4'hF;
    s_if.readdata = 32'h1234_5678;
    mid(); chk("rd0_c0_grant", grant, 2'b00); adv();
    mid();
    chk("rd0_c1_grant", grant, 2'b01);
    chk("rd0_c1_wait", m0_if.waitrequest, 1'b0);
    chk("rd0_c1_rdata", m0_if.readdata, 32'h1234_5678);
    chk("rd0_c1_s_addr", s_if.address, 32'hBFC0_0000);
    adv();
    m_clear();
    mid(); chk("rd0_c2_grant", grant, 2'b00); adv();

    // m1 write with 3 stall cycles
    m1_if.write = 1'b1; m1_if.address = 32'h0000_1000; m1_if.writedata = 32'hDEAD_BEEF; m1_if.byteenable = 4'hF;
    s_if.waitrequest = 1'b1;
    mid(); adv();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("wr1_stall_grant", grant, 2'b10);
      chk("wr1_stall_s_write", s_if.write, 1'b1);
      chk("wr1_stall_wait", m1_if.waitrequest, 1'b1);
      adv();
    end
    s_if.waitrequest = 1'b0;
    mid();
    chk("wr1_done_grant", grant, 2'b10);
    chk("wr1_done_s_write", s_if.write, 1'b1);
    chk("wr1_done_wdata", s_if.writedata, 32'hDEAD_BEEF);
    chk("wr1_done_wait", m1_if.waitrequest, 1'b0);
    adv();
    m_clear();
    mid(); chk("wr1_idle", grant, 2'b00); adv();

    // Continuous contention: 8 cycles give four grants
    m0_if.read = 1'b1; m1_if.read = 1'b1;
    gseq.delete();
    for (int i = 0; i < 8; i++) begin
      mid();
      if (grant != 2'b00) gseq.push_back(grant);
      adv();
    end
    chk("contend_count", gseq.size(), 4);
    for (int i = 0; i < gseq.size(); i++)
      chk("contend_order", gseq[i], RR ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b01);

    // m0 drops its read mid-grant while m1 waits
    m1_if.read = 1'b0;
    s_if.waitrequest = 1'b1;
    mid(); adv();
    m1_if.read = 1'b1;
    mid(); chk("drop_g0", grant, 2'b01); adv();
    m0_if.read = 1'b0;
    mid();
    chk("drop_s_read", s_if.read, 1'b0);
    chk("drop_grant_held", grant, 2'b01);
    adv();
    mid(); chk("drop_idle", grant, 2'b00); adv();
    mid(); chk("drop_m1_granted", grant, 2'b10); chk("drop_m1_s_read", s_if.read, 1'b1); adv();
    s_if.waitrequest = 1'b0;
    mid(); adv();
    m_clear();
    mid(); adv();

    // Stuck slave: timeout after the 8th stall cycle, sticky afterwards
    m0_if.write = 1'b1; m0_if.address = 32'h0000_0040; m0_if.writedata = 32'hA5A5_5A5A; m0_if.byteenable = 4'h3;
    s_if.waitrequest = 1'b1;
    mid(); adv();
    for (int i = 0; i < TMO; i++) begin
      mid(); chk("tmo_pending", timeout, 1'b0); adv();
    end
    s_if.waitrequest = 1'b0;
    mid(); chk("tmo_set", timeout, 1'b1); adv();
    m_clear();
    mid(); chk("tmo_sticky", timeout, 1'b1); chk("tmo_off_copy", timeout_z, 1'b0); adv();

    // Asynchronous reset in the middle of a granted read
    m0_if.read = 1'b1; m0_if.address = 32'h0000_0100;
    s_if.waitrequest = 1'b1;
    mid(); adv();
    mid(); chk("rst_pre_s_read", s_if.read, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rst_s_read", s_if.read, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_m0_wait", m0_if.waitrequest, 1'b1);
    chk("rst_m1_wait", m1_if.waitrequest, 1'b1);
    model_reset();
    m_clear();
    s_if.waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic from two well-behaved masters
    act0 = 1'b0; act1 = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      mid();
      done0 = act0 && !m0_if.waitrequest;
      done1 = act1 && !m1_if.waitrequest;
      adv();
      if (done0) begin act0 = 1'b0; m0_if.read = 1'b0; m0_if.write = 1'b0; end
      if (done1) begin act1 = 1'b0; m1_if.read = 1'b0; m1_if.write = 1'b0; end
      if (!act0 && $urandom_range(0, 2) == 0) begin
        act0 = 1'b1;
        m0_if.write = $urandom_range(0, 1) == 1;
        m0_if.read = !m0_if.write;
        m0_if.address = $urandom; m0_if.writedata = $urandom;
        m0_if.byteenable = 4'($urandom_range(1, 15));
      end
      if (!act1 && $urandom_range(0, 2) == 0) begin
        act1 = 1'b1;
        m1_if.write = $urandom_range(0, 1) == 1;
        m1_if.read = !m1_if.write;
        m1_if.address = $urandom; m1_if.writedata = $urandom;
        m1_if.byteenable = 4'($urandom_range(1, 15));
      end
      s_if.waitrequest = ($urandom_range(0, 2) == 0);
      s_if.readdata = $urandom;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
